mavg_arbiter: RTL and testbench

MAVG_ARBITER -- requirements
Module: mavg_arbiter

---
 rtl/mavg_arbiter.sv | 149 ++++++++++++++
 tb/tb_mavg_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mavg_arbiter.sv
// mavg_arbiter: round-robin arbiter feeding x/y/t samples into a shared moving-average
// datapath, with a three-step window-clear (flush) sequence and per-channel fill counters.
`default_nettype none

module mavg_arbiter #(
    parameter int WINDOW_SIZE = 4,
    parameter int DATA_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          i_req,
    input  logic [3*DATA_W-1:0] i_sample,
    input  logic                i_flush,
    output logic [2:0]          o_gnt,
    output logic                o_dp_valid,
    output logic                o_dp_clear,
    output logic [1:0]          o_dp_chan,
    output logic [DATA_W-1:0]   o_dp_data,
    input  logic                i_dp_ready,
    output logic [2:0]          o_win_full,
    output logic                o_busy
);

    localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
    localparam logic [CNT_W-1:0] c_WIN = CNT_W'(WINDOW_SIZE);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_ptr;
    logic              r_flush_pend;
    logic              r_dp_valid;
    logic              r_dp_clear;
    logic [1:0]        r_dp_chan;
    logic [DATA_W-1:0] r_dp_data;
    logic [CNT_W-1:0]  r_cnt [3];

    logic              w_issue_hs;
    logic              w_flush_arr;
    logic              w_enter_flush;
    logic              w_grant_ok;
    logic              w_grant;
    logic [1:0]        w_sel_chan;
    logic [DATA_W-1:0] w_sel_data;
    logic [1:0]        w_ptr_next;

    assign w_issue_hs    = (r_state == c_ISSUE) && i_dp_ready;
    assign w_flush_arr   = i_flush && (r_state != c_FLUSH);
    assign w_enter_flush = r_flush_pend && ((r_state == c_IDLE) || w_issue_hs);
    // A pending or newly arriving flush always beats a grant.
    assign w_grant_ok    = ((r_state == c_IDLE) || w_issue_hs) && !r_flush_pend && !w_flush_arr;
    assign w_grant       = rst_n && w_grant_ok && (|i_req);

    always_comb begin
        w_sel_chan = 2'd0;
        case (r_ptr)
            2'd1:    w_sel_chan = i_req[1] ? 2'd1 : (i_req[2] ? 2'd2 : 2'd0);
            2'd2:    w_sel_chan = i_req[2] ? 2'd2 : (i_req[0] ? 2'd0 : 2'd1);
            default: w_sel_chan = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_sel_data = i_sample[DATA_W-1:0];
        case (w_sel_chan)
            2'd1:    w_sel_data = i_sample[2*DATA_W-1:DATA_W];
            2'd2:    w_sel_data = i_sample[3*DATA_W-1:2*DATA_W];
            default: w_sel_data = i_sample[DATA_W-1:0];
        endcase
    end

    assign w_ptr_next = (w_sel_chan == 2'd2) ? 2'd0 : (w_sel_chan + 2'd1);
    assign o_gnt      = w_grant ? (3'b001 << w_sel_chan) : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_ptr        <= 2'd0;
            r_flush_pend <= 1'b0;
            r_dp_valid   <= 1'b0;
            r_dp_clear   <= 1'b0;
            r_dp_chan    <= 2'd0;
            r_dp_data    <= '0;
        end else begin
            if (w_enter_flush) begin
                r_flush_pend <= 1'b0;
            end else if (w_flush_arr) begin
                r_flush_pend <= 1'b1;
            end
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end

            if (w_enter_flush) begin
                r_state    <= c_FLUSH;
                r_dp_valid <= 1'b0;
                r_dp_clear <= 1'b1;
                r_dp_chan  <= 2'd0;
                r_dp_data  <= '0;
            end else if (w_grant) begin
                r_state    <= c_ISSUE;
                r_dp_valid <= 1'b1;
                r_dp_chan  <= w_sel_chan;
                r_dp_data  <= w_sel_data;
            end else if (w_issue_hs) begin
                r_state    <= c_IDLE;
                r_dp_valid <= 1'b0;
            end else if ((r_state == c_FLUSH) && i_dp_ready) begin
                if (r_dp_chan == 2'd2) begin
                    r_state    <= c_IDLE;
                    r_dp_clear <= 1'b0;
                    r_dp_chan  <= 2'd0;
                end else begin
                    r_dp_chan <= r_dp_chan + 2'd1;
                end
            end else if (r_state == 2'd3) begin
                r_state <= c_IDLE;
            end
        end
    end

    generate
        for (genvar k = 0; k < 3; k++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[k] <= '0;
                end else if (i_dp_ready && (r_dp_chan == 2'(k))) begin
                    if (r_dp_clear) begin
                        r_cnt[k] <= '0;
                    end else if (r_dp_valid && (r_cnt[k] != c_WIN)) begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
            assign o_win_full[k] = (r_cnt[k] == c_WIN);
        end
    endgenerate

    assign o_dp_valid = r_dp_valid;
    assign o_dp_clear = r_dp_clear;
    assign o_dp_chan  = r_dp_chan;
    assign o_dp_data  = r_dp_data;
    assign o_busy     = (r_state != c_IDLE) || r_flush_pend;

endmodule

`default_nettype wire

// File: tb/tb_mavg_arbiter.sv
// tb_mavg_arbiter: randomized + directed bench; a cycle-level behavioural model predicts
// grants and status, a scoreboard queue checks every datapath command at its handshake.
`default_nettype none

module tb_mavg_arbiter;

    localparam int W  = 4;
    localparam int DW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      i_req = '0;
    logic [3*DW-1:0] i_sample = '0;
    logic            i_flush = 1'b0;
    logic            i_dp_ready = 1'b0;
    logic [2:0]      o_gnt;
    logic            o_dp_valid;
    logic            o_dp_clear;
    logic [1:0]      o_dp_chan;
    logic [DW-1:0]   o_dp_data;
    logic [2:0]      o_win_full;
    logic            o_busy;

    mavg_arbiter #(.WINDOW_SIZE(W), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_sample   (i_sample),
        .i_flush    (i_flush),
        .o_gnt      (o_gnt),
        .o_dp_valid (o_dp_valid),
        .o_dp_clear (o_dp_clear),
        .o_dp_chan  (o_dp_chan),
        .o_dp_data  (o_dp_data),
        .i_dp_ready (i_dp_ready),
        .o_win_full (o_win_full),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr;
        int chan;
        int data;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] rq, input int p);
        for (int i = 0; i < 3; i++) begin
            if (rq[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    // Behavioural model: is a sample command outstanding, which clear step is active.
    bit         m_cmd;
    int         m_chan;
    int         m_clr;
    bit         m_pend;
    int         m_rr;
    int         m_cnt [3];
    bit         p_farr, p_idle, p_elig, p_enter;
    int         p_k;
    logic [2:0] p_eg, p_full;

    always @(negedge clk) begin : predictor
        if (!rst_n) begin
            chk("reset_outputs", {o_gnt, o_dp_valid, o_dp_clear, o_dp_chan, o_dp_data, o_win_full, o_busy}, 32'd0);
            m_cmd = 0; m_chan = 0; m_clr = -1; m_pend = 0; m_rr = 0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
            exp_q.delete();
        end else begin
            p_farr = i_flush && (m_clr < 0);
            for (int k = 0; k < 3; k++) p_full[k] = (m_cnt[k] == W);
            chk("dp_valid", o_dp_valid, m_cmd);
            chk("dp_clear", o_dp_clear, m_clr >= 0);
            chk("busy", o_busy, m_cmd || (m_clr >= 0) || m_pend);
            chk("win_full", o_win_full, p_full);

            p_idle  = !m_cmd && (m_clr < 0);
            p_elig  = (p_idle || (m_cmd && i_dp_ready)) && !m_pend && !p_farr;
            p_k     = p_elig ? rr_pick(i_req, m_rr) : -1;
            p_eg    = (p_k >= 0) ? (3'b001 << p_k) : 3'b000;
            chk("gnt", o_gnt, p_eg);
            p_enter = m_pend && (p_idle || (m_cmd && i_dp_ready));

            if (i_dp_ready && m_cmd) begin
                if (m_cnt[m_chan] < W) m_cnt[m_chan]++;
                m_cmd = 0;
            end
            if (i_dp_ready && (m_clr >= 0)) begin
                m_cnt[m_clr] = 0;
                m_clr = (m_clr == 2) ? -1 : m_clr + 1;
            end
            if (p_k >= 0) begin
                m_cmd  = 1;
                m_chan = p_k;
                m_rr   = (p_k + 1) % 3;
                exp_q.push_back('{0, p_k, int'((i_sample >> (p_k * DW)) & ((1 << DW) - 1))});
            end
            if (p_enter) begin
                m_pend = 0;
                m_clr  = 0;
                for (int c = 0; c < 3; c++) exp_q.push_back('{1, c, 0});
            end else if (p_farr) begin
                m_pend = 1;
            end
        end
    end

    cmd_t got;

    always @(negedge clk) begin : monitor
        if (rst_n && (o_dp_valid || o_dp_clear) && i_dp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dp_unexpected at %0t: got chan %0d clear %0b, expected no command", $time, o_dp_chan, o_dp_clear);
            end else begin
                got = exp_q.pop_front();
                chk("dp_kind", o_dp_clear, got.clr);
                chk("dp_chan", o_dp_chan, got.chan);
                if (!got.clr) chk("dp_data", o_dp_data, got.data);
            end
        end
    end

    task automatic step(input logic [2:0] rq, input logic [3*DW-1:0] smp, input logic fl, input logic rdy);
        i_req = rq; i_sample = smp; i_flush = fl; i_dp_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit fl_prev;
        bit hit;
        @(posedge clk); #2;
        repeat (3) step(3'b111, 6'h3F, 1'b1, 1'b1);
        rst_n = 1'b1;

        // All channels requesting, datapath always ready: x, y, t rotation until full.
        repeat (14) step(3'b111, 6'($urandom), 1'b0, 1'b1);
        step(3'b000, '0, 1'b0, 1'b1);

        // Single y grant stalled for three cycles.
        step(3'b010, 6'b00_10_00, 1'b0, 1'b0);
        repeat (3) step(3'b000, '0, 1'b0, 1'b0);
        step(3'b000, '0, 1'b0, 1'b1);

        // Flush pulse during a stalled transfer.
        step(3'b001, 6'b00_00_11, 1'b0, 1'b0);
        step(3'b000, '0, 1'b1, 1'b0);
        step(3'b000, '0, 1'b0, 1'b0);
        repeat (8) step(3'b000, '0, 1'b0, 1'b1);

        // Flush coincident with an x request while idle.
        step(3'b001, 6'b00_00_01, 1'b1, 1'b1);
        repeat (8) step(3'b001, 6'b00_00_10, 1'b0, 1'b1);
        step(3'b000, '0, 1'b0, 1'b1);

        // Six x transfers saturate the x window.
        repeat (6) step(3'b001, 6'($urandom), 1'b0, 1'b1);
        step(3'b000, '0, 1'b0, 1'b1);

        fl_prev = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic fl;
            fl = !fl_prev && ($urandom_range(0, 19) == 0);
            fl_prev = fl;
            step(3'($urandom), 6'($urandom), fl, $urandom_range(0, 9) < 7);
        end
        repeat (6) step(3'b000, '0, 1'b0, 1'b1);

        // Reset asserted while the clear sequence sits at channel 1.
        step(3'b000, '0, 1'b1, 1'b1);
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            if (o_dp_clear && (o_dp_chan == 2'd1)) hit = 1'b1;
            else step(3'b000, '0, 1'b0, 1'b1);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL flush_chan1_timeout at %0t: clear step 1 not reached, expected within 50 cycles", $time);
        end
        step(3'b000, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(3'b111, 6'h15, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (6) step(3'b000, '0, 1'b0, 1'b1);
        repeat (4) step(3'b111, 6'($urandom), 1'b0, 1'b1);
        repeat (8) step(3'b000, '0, 1'b0, 1'b1);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
